// File: rtl/riscv_muldiv.sv
// riscv_muldiv: iterative RV32M/RV64M multiply/divide unit for the Execute stage.
//   Multiply is shift-add and divide is restoring division, both on operand
//   magnitudes. Each takes XLEN/UNROLL iteration cycles, and the sign is fixed
//   up at the end. Divide-by-zero and signed overflow skip the iterations and
//   take a one-cycle fast path.
// Ports:
//   clk, reset     rising-edge clock; asynchronous active-high reset
//   start          issue op (honoured only in IDLE and only without flush)
//   funct3         RV32M/RV64M op select (MUL..REMU)
//   srca, srcb     rs1 / rs2 operands, latched at start
//   rdIn           destination tag, latched at start
//   flush          abort the op in flight
//   busy           op in flight (iteration or fast-path cycle)
//   done           one-cycle pulse: result/rdOut valid
//   result, rdOut  last completed result and tag, held between ops
module riscv_muldiv #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic [4:0]      rdIn,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rdOut
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N);
  localparam int AW = 2 * XLEN + 1;

  typedef enum logic [1:0] {IDLE, CALC, FAST, FIN} state_t;

  state_t            state, nextState;
  logic [AW-1:0]     acc, stepAcc, t;
  logic [XLEN-1:0]   opB;
  logic              isDiv, hiHalf, remOp, negRes;
  logic [CW-1:0]     count;
  logic [4:0]        rdReg;

  logic              sgnA, sgnB, negA, negB, divZero, ovf, fastPath, accept;
  logic [XLEN-1:0]   magA, magB, fastVal, selD, finalRes;
  logic [XLEN:0]     sum;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] prod;

  // Operand decode, evaluated on the raw inputs for the start cycle.
  always_comb begin
    sgnA     = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    sgnB     = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    negA     = sgnA && srca[XLEN-1];
    negB     = sgnB && srcb[XLEN-1];
    magA     = negA ? (~srca + 1'b1) : srca;
    magB     = negB ? (~srcb + 1'b1) : srcb;
    divZero  = funct3[2] && (srcb == '0);
    ovf      = funct3[2] && !funct3[0] &&
               (srca == {1'b1, {(XLEN-1){1'b0}}}) && (srcb == '1);
    fastPath = divZero || ovf;
    if (divZero) fastVal = funct3[1] ? srca : '1;
    else         fastVal = funct3[1] ? '0 : srca;
    accept   = (state == IDLE) && start && !flush;
  end

  // UNROLL iteration steps per cycle. Accumulator layout is
  // {upper XLEN+1 bits, lower XLEN bits}: for multiply the upper part is the
  // running partial product and the lower part the remaining multiplier bits;
  // for divide the upper part is the partial remainder and the lower part
  // shifts dividend bits out and quotient bits in.
  always_comb begin
    t    = acc;
    sum  = '0;
    diff = '0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (isDiv) begin
        t    = t << 1;
        diff = {1'b0, t[AW-1:XLEN]} - {2'b00, opB};
        if (!diff[XLEN+1]) begin
          t[AW-1:XLEN] = diff[XLEN:0];
          t[0]         = 1'b1;
        end
      end else begin
        sum = t[AW-1:XLEN] + {1'b0, opB & {XLEN{t[0]}}};
        t   = {sum, t[XLEN-1:0]} >> 1;
      end
    end
    stepAcc = t;
  end

  // Sign fix-up on the accumulator after the final step.
  always_comb begin
    selD = remOp ? stepAcc[2*XLEN-1:XLEN] : stepAcc[XLEN-1:0];
    prod = negRes ? (~stepAcc[2*XLEN-1:0] + 1'b1) : stepAcc[2*XLEN-1:0];
    if (isDiv) finalRes = negRes ? (~selD + 1'b1) : selD;
    else       finalRes = hiHalf ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = fastPath ? FAST : CALC;
      CALC: begin
        if (flush)                     nextState = IDLE;
        else if (count == CW'(N - 1))  nextState = FIN;
      end
      FAST: nextState = flush ? IDLE : FIN;
      FIN:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign busy = (state == CALC) || (state == FAST);
  assign done = (state == FIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      opB    <= '0;
      isDiv  <= 1'b0;
      hiHalf <= 1'b0;
      remOp  <= 1'b0;
      negRes <= 1'b0;
      count  <= '0;
      rdReg  <= '0;
      result <= '0;
      rdOut  <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: if (accept) begin
          opB    <= funct3[2] ? magB : magA;
          isDiv  <= funct3[2];
          hiHalf <= (funct3[1:0] != 2'b00);
          remOp  <= funct3[2] & funct3[1];
          negRes <= (funct3[2] & funct3[1]) ? negA : (negA ^ negB);
          rdReg  <= rdIn;
          count  <= '0;
          // The fast-path value waits in the accumulator so that a flush
          // during the fast cycle leaves result untouched.
          if (fastPath) acc <= {{(XLEN+1){1'b0}}, fastVal};
          else          acc <= {{(XLEN+1){1'b0}}, funct3[2] ? magA : magB};
        end
        CALC: begin
          if (flush) begin
            count <= '0;
          end else begin
            acc <= stepAcc;
            if (count == CW'(N - 1)) begin
              count  <= '0;
              result <= finalRes;
              rdOut  <= rdReg;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        FAST: if (!flush) begin
          result <= acc[XLEN-1:0];
          rdOut  <= rdReg;
        end
        default: ;
      endcase
    end
  end

endmodule
